// File: rtl/rx_cmd_ctrl.sv
// Command-frame decoder behind the UART receiver: turns byte frames into
// register-file accesses and ALU operations, and returns results over the TX handshake.
`timescale 1ns/1ps
module rx_cmd_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned FUN_WIDTH  = 4,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   rx_p_data,
  input  logic                    rx_d_vld,
  input  logic                    rx_err,
  input  logic [DATA_WIDTH-1:0]   rf_rd_data,
  input  logic                    rf_rd_data_vld,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_out_vld,
  input  logic                    tx_busy,
  output logic [ADDR_WIDTH-1:0]   rf_address,
  output logic                    rf_wr_en,
  output logic                    rf_rd_en,
  output logic [DATA_WIDTH-1:0]   rf_wr_data,
  output logic [FUN_WIDTH-1:0]    alu_fun,
  output logic                    alu_en,
  output logic                    clk_gate_en,
  output logic [DATA_WIDTH-1:0]   tx_p_data,
  output logic                    tx_d_vld
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B,
    ALU_FUN, ALU_WAIT, SEND_LO, SEND_HI
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        tmo_cnt, tmo_cnt_nxt;
  logic [DATA_WIDTH-1:0]   data_lo, data_lo_nxt;
  logic [DATA_WIDTH-1:0]   data_hi, data_hi_nxt;
  logic                    two_byte, two_byte_nxt;
  logic [ADDR_WIDTH-1:0]   rf_address_nxt;
  logic                    rf_wr_en_nxt, rf_rd_en_nxt;
  logic [DATA_WIDTH-1:0]   rf_wr_data_nxt;
  logic [FUN_WIDTH-1:0]    alu_fun_nxt;
  logic                    alu_en_nxt, clk_gate_en_nxt;
  logic [DATA_WIDTH-1:0]   tx_p_data_nxt;
  logic                    tx_d_vld_nxt;
  logic                    byte_ok;
  logic                    in_frame;

  assign byte_ok  = rx_d_vld & ~rx_err;
  assign in_frame = state inside {WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN};

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      data_lo     <= '0;
      data_hi     <= '0;
      two_byte    <= 1'b0;
      rf_address  <= '0;
      rf_wr_en    <= 1'b0;
      rf_rd_en    <= 1'b0;
      rf_wr_data  <= '0;
      alu_fun     <= '0;
      alu_en      <= 1'b0;
      clk_gate_en <= 1'b0;
      tx_p_data   <= '0;
      tx_d_vld    <= 1'b0;
    end else begin
      state       <= state_nxt;
      tmo_cnt     <= tmo_cnt_nxt;
      data_lo     <= data_lo_nxt;
      data_hi     <= data_hi_nxt;
      two_byte    <= two_byte_nxt;
      rf_address  <= rf_address_nxt;
      rf_wr_en    <= rf_wr_en_nxt;
      rf_rd_en    <= rf_rd_en_nxt;
      rf_wr_data  <= rf_wr_data_nxt;
      alu_fun     <= alu_fun_nxt;
      alu_en      <= alu_en_nxt;
      clk_gate_en <= clk_gate_en_nxt;
      tx_p_data   <= tx_p_data_nxt;
      tx_d_vld    <= tx_d_vld_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt       = state;
    tmo_cnt_nxt     = '0;
    data_lo_nxt     = data_lo;
    data_hi_nxt     = data_hi;
    two_byte_nxt    = two_byte;
    rf_address_nxt  = rf_address;
    rf_wr_en_nxt    = 1'b0;
    rf_rd_en_nxt    = rf_rd_en;
    rf_wr_data_nxt  = rf_wr_data;
    alu_fun_nxt     = alu_fun;
    alu_en_nxt      = alu_en;
    clk_gate_en_nxt = clk_gate_en;
    tx_p_data_nxt   = tx_p_data;
    tx_d_vld_nxt    = tx_d_vld;

    case (state)
      IDLE: begin
        if (byte_ok) begin
          if (rx_p_data == CMD_WR)          state_nxt = WR_ADDR;
          else if (rx_p_data == CMD_RD)     state_nxt = RD_ADDR;
          else if (rx_p_data == CMD_ALU_OP) state_nxt = ALU_A;
          else if (rx_p_data == CMD_ALU_NO) state_nxt = ALU_FUN;
        end
      end
      WR_ADDR: if (byte_ok) begin
        rf_address_nxt = rx_p_data[ADDR_WIDTH-1:0];
        state_nxt      = WR_DATA;
      end
      WR_DATA: if (byte_ok) begin
        rf_wr_en_nxt   = 1'b1;
        rf_wr_data_nxt = rx_p_data;
        state_nxt      = IDLE;
      end
      RD_ADDR: if (byte_ok) begin
        rf_address_nxt = rx_p_data[ADDR_WIDTH-1:0];
        rf_rd_en_nxt   = 1'b1;
        state_nxt      = RD_WAIT;
      end
      RD_WAIT: if (rf_rd_data_vld) begin
        data_lo_nxt  = rf_rd_data;
        two_byte_nxt = 1'b0;
        rf_rd_en_nxt = 1'b0;
        state_nxt    = SEND_LO;
      end
      ALU_A: if (byte_ok) begin
        rf_wr_en_nxt   = 1'b1;
        rf_address_nxt = '0;
        rf_wr_data_nxt = rx_p_data;
        state_nxt      = ALU_B;
      end
      ALU_B: if (byte_ok) begin
        rf_wr_en_nxt   = 1'b1;
        rf_address_nxt = ADDR_WIDTH'(1);
        rf_wr_data_nxt = rx_p_data;
        state_nxt      = ALU_FUN;
      end
      ALU_FUN: if (byte_ok) begin
        alu_fun_nxt     = rx_p_data[FUN_WIDTH-1:0];
        alu_en_nxt      = 1'b1;
        clk_gate_en_nxt = 1'b1;
        state_nxt       = ALU_WAIT;
      end
      ALU_WAIT: if (alu_out_vld) begin
        data_lo_nxt     = alu_out[DATA_WIDTH-1:0];
        data_hi_nxt     = alu_out[2*DATA_WIDTH-1:DATA_WIDTH];
        two_byte_nxt    = 1'b1;
        alu_en_nxt      = 1'b0;
        clk_gate_en_nxt = 1'b0;
        state_nxt       = SEND_LO;
      end
      SEND_LO, SEND_HI: begin
        // Request is raised only on an idle transmitter and withdrawn once it takes the byte
        if (!tx_d_vld) begin
          if (!tx_busy) begin
            tx_d_vld_nxt  = 1'b1;
            tx_p_data_nxt = (state == SEND_LO) ? data_lo : data_hi;
          end
        end else if (tx_busy) begin
          tx_d_vld_nxt = 1'b0;
          state_nxt    = (state == SEND_LO && two_byte) ? SEND_HI : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Frame abort on a corrupted byte or an inter-byte gap that is too long
    if (in_frame) begin
      if (rx_d_vld && rx_err) begin
        state_nxt      = IDLE;
        rf_wr_en_nxt   = 1'b0;
        rf_rd_en_nxt   = 1'b0;
        alu_en_nxt     = alu_en;
      end else if (!rx_d_vld) begin
        if (tmo_cnt == CNT_W'(TIMEOUT - 1)) state_nxt = IDLE;
        else tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// Directed bench for rx_cmd_ctrl: frame decoding, RF/ALU strobes, TX handshake,
// error/timeout aborts and asynchronous reset.
`timescale 1ns/1ps
module tb_rx_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_p_data;
  logic        rx_d_vld, rx_err;
  logic [7:0]  rf_rd_data;
  logic        rf_rd_data_vld;
  logic [15:0] alu_out;
  logic        alu_out_vld;
  logic        tx_busy;
  logic [3:0]  rf_address;
  logic        rf_wr_en, rf_rd_en;
  logic [7:0]  rf_wr_data;
  logic [3:0]  alu_fun;
  logic        alu_en, clk_gate_en;
  logic [7:0]  tx_p_data;
  logic        tx_d_vld;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int overlap = 0;
  int snap;
  int vld_seen;

  rx_cmd_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .rx_p_data(rx_p_data), .rx_d_vld(rx_d_vld), .rx_err(rx_err),
    .rf_rd_data(rf_rd_data), .rf_rd_data_vld(rf_rd_data_vld),
    .alu_out(alu_out), .alu_out_vld(alu_out_vld), .tx_busy(tx_busy),
    .rf_address(rf_address), .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en),
    .rf_wr_data(rf_wr_data), .alu_fun(alu_fun), .alu_en(alu_en),
    .clk_gate_en(clk_gate_en), .tx_p_data(tx_p_data), .tx_d_vld(tx_d_vld)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_wr_en) wr_cnt <= wr_cnt + 1;
    if (rf_wr_en && rf_rd_en) overlap <= overlap + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err);
    rx_p_data = b;
    rx_d_vld  = 1'b1;
    rx_err    = err;
    tick();
    rx_d_vld  = 1'b0;
    rx_err    = 1'b0;
  endtask

  task automatic wait_tx(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (tx_d_vld) break;
      tick();
    end
    check(tag, tx_d_vld, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {rf_address, rf_wr_en, rf_rd_en, rf_wr_data, alu_fun,
                           alu_en, clk_gate_en, tx_p_data, tx_d_vld}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_p_data = '0; rx_d_vld = 1'b0; rx_err = 1'b0;
    rf_rd_data = '0; rf_rd_data_vld = 1'b0;
    alu_out = '0; alu_out_vld = 1'b0; tx_busy = 1'b0;
    #23;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    check_all_zero("post_reset");

    // Write frame AA,05,3C
    send_byte(8'hAA, 0);
    send_byte(8'h05, 0);
    send_byte(8'h3C, 0);
    check("wr_en", rf_wr_en, 1);
    check("wr_addr", rf_address, 5);
    check("wr_data", rf_wr_data, 8'h3C);
    tick();
    check("wr_en_pulse", rf_wr_en, 0);

    // Read frame BB,07 with data returned after 3 cycles
    send_byte(8'hBB, 0);
    send_byte(8'h07, 0);
    check("rd_addr", rf_address, 7);
    check("rd_en_c1", rf_rd_en, 1);
    tick();
    check("rd_en_c2", rf_rd_en, 1);
    tick();
    check("rd_en_c3", rf_rd_en, 1);
    rf_rd_data = 8'h9E; rf_rd_data_vld = 1'b1;
    tick();
    rf_rd_data_vld = 1'b0;
    check("rd_en_drop", rf_rd_en, 0);
    wait_tx("rd_tx_vld");
    check("rd_tx_data", tx_p_data, 8'h9E);
    tick(); tick();
    check("rd_tx_hold", {tx_d_vld, tx_p_data}, {1'b1, 8'h9E});
    tx_busy = 1'b1;
    tick();
    check("rd_tx_drop", tx_d_vld, 0);
    tick(); tx_busy = 1'b0;
    tick(); tick(); tick();
    check("rd_tx_once", tx_d_vld, 0);

    // ALU frame CC,12,34,00 returning 0x0046
    send_byte(8'hCC, 0);
    send_byte(8'h12, 0);
    check("alu_a_wr", {rf_wr_en, rf_address, rf_wr_data}, {1'b1, 4'h0, 8'h12});
    send_byte(8'h34, 0);
    check("alu_b_wr", {rf_wr_en, rf_address, rf_wr_data}, {1'b1, 4'h1, 8'h34});
    send_byte(8'h00, 0);
    check("alu_start", {alu_en, clk_gate_en, alu_fun}, {1'b1, 1'b1, 4'h0});
    tick(); tick(); tick();
    check("alu_hold", {alu_en, clk_gate_en}, 2'b11);
    alu_out = 16'h0046; alu_out_vld = 1'b1;
    tick();
    alu_out_vld = 1'b0;
    check("alu_done", {alu_en, clk_gate_en}, 2'b00);
    wait_tx("alu_lo_vld");
    check("alu_lo_data", tx_p_data, 8'h46);
    tx_busy = 1'b1;
    tick();
    check("alu_lo_drop", tx_d_vld, 0);
    vld_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (tx_d_vld) vld_seen++;
    end
    check("alu_hi_waits_busy", vld_seen, 0);
    tx_busy = 1'b0;
    wait_tx("alu_hi_vld");
    check("alu_hi_data", tx_p_data, 8'h00);
    tx_busy = 1'b1;
    tick();
    check("alu_hi_drop", tx_d_vld, 0);
    tx_busy = 1'b0;
    tick(); tick();

    // Errored byte aborts the frame, next frame works
    snap = wr_cnt;
    send_byte(8'hAA, 0);
    send_byte(8'h05, 0);
    send_byte(8'h3C, 1);
    tick(); tick();
    check("err_no_write", wr_cnt - snap, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    check("after_err_wr", {rf_wr_en, rf_address, rf_wr_data}, {1'b1, 4'h2, 8'h11});

    // Gap just under the timeout keeps the frame alive
    tick();
    snap = wr_cnt;
    send_byte(8'hAA, 0);
    repeat (1000) tick();
    send_byte(8'h06, 0);
    send_byte(8'h5A, 0);
    check("gap_ok_wr", {rf_wr_en, rf_address, rf_wr_data}, {1'b1, 4'h6, 8'h5A});
    tick();

    // Gap beyond the timeout returns to IDLE
    snap = wr_cnt;
    send_byte(8'hAA, 0);
    repeat (1100) tick();
    send_byte(8'h05, 0);
    send_byte(8'h3C, 0);
    tick(); tick();
    check("timeout_no_write", wr_cnt - snap, 0);

    // DD,03 with transmitter busy, then reset during SEND_HI
    send_byte(8'hDD, 0);
    send_byte(8'h03, 0);
    check("dd_start", {alu_en, clk_gate_en, alu_fun}, {1'b1, 1'b1, 4'h3});
    tx_busy = 1'b1;
    alu_out = 16'h1234; alu_out_vld = 1'b1;
    tick();
    alu_out_vld = 1'b0;
    vld_seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tx_d_vld) vld_seen++;
    end
    check("dd_busy_block", vld_seen, 0);
    tx_busy = 1'b0;
    wait_tx("dd_lo_vld");
    check("dd_lo_data", tx_p_data, 8'h34);
    tx_busy = 1'b1;
    tick();
    tx_busy = 1'b0;
    wait_tx("dd_hi_vld");
    check("dd_hi_data", tx_p_data, 8'h12);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    #2 rst_n = 1'b1;
    tick(); tick();
    check("post_reset_tx", tx_d_vld, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h09, 0);
    send_byte(8'h77, 0);
    check("post_reset_wr", {rf_wr_en, rf_address, rf_wr_data}, {1'b1, 4'h9, 8'h77});
    tick();
    check("no_wr_rd_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_cmd_ctrl.md
Name: rx_cmd_ctrl

Overview:
Command-frame decoder directly downstream of the UART receiver. It consumes the byte stream (parallel byte, valid strobe, error flag) after synchronisation into this clock domain. It parses 4 frame types into register-file writes/reads and ALU operations, and returns read data or ALU results to the UART transmitter through a busy-based handshake.

Parameters:
DATA_WIDTH, 8, byte width of RX, TX and register-file data
ADDR_WIDTH, 4, register-file address width
FUN_WIDTH, 4, ALU function code width
TIMEOUT, 1023, maximum CLK cycles allowed between bytes of one frame

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
RX_P_DATA  in  DATA_WIDTH  received byte
RX_D_VLD  in  1  one-cycle pulse, RX_P_DATA valid
RX_ERR  in  1  parity or framing error, qualified by RX_D_VLD
RF_RdData  in  DATA_WIDTH  register-file read data
RF_RdData_VLD  in  1  read data valid
ALU_OUT  in  2*DATA_WIDTH  ALU result
ALU_OUT_VLD  in  1  ALU result valid
TX_BUSY  in  1  transmitter busy
RF_Address  out  ADDR_WIDTH  register-file address
RF_WrEn  out  1  write strobe
RF_RdEn  out  1  read request
RF_WrData  out  DATA_WIDTH  write data
ALU_FUN  out  FUN_WIDTH  ALU function
ALU_EN  out  1  ALU enable
CLK_GATE_EN  out  1  ALU clock-gate enable
TX_P_DATA  out  DATA_WIDTH  byte to transmit
TX_D_VLD  out  1  transmit request

Behaviour:
- Reset: all outputs 0; FSM in IDLE; timeout counter 0.
- A byte is accepted only on RX_D_VLD=1. If RX_ERR=1 on the same cycle, the byte is discarded. Mid-frame, the FSM returns to IDLE and no RF/ALU strobe issues for that frame.
- IDLE: 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; 0xCC -> ALU_A; 0xDD -> ALU_FUN. Any other byte is ignored (stay IDLE).
- WR_ADDR: latch RX_P_DATA[ADDR_WIDTH-1:0] -> WR_DATA. WR_DATA: on byte, RF_WrEn=1 for 1 cycle with latched address and data -> IDLE.
- RD_ADDR: on byte, RF_Address=byte and RF_RdEn=1 -> RD_WAIT. RF_RdEn stays high until RF_RdData_VLD.
- RD_WAIT: on RF_RdData_VLD, latch data, drop RF_RdEn -> SEND_LO (1 byte).
- ALU_A: byte written to RF address 0 (RF_WrEn pulse) -> ALU_B.
- ALU_B: byte written to RF address 1 -> ALU_FUN.
- ALU_FUN: on byte, ALU_FUN=byte[FUN_WIDTH-1:0], CLK_GATE_EN=1, ALU_EN=1 -> ALU_WAIT.
- ALU_WAIT: hold ALU_EN and CLK_GATE_EN. On ALU_OUT_VLD, latch the 16-bit result, drop ALU_EN and CLK_GATE_EN -> SEND_LO (2 bytes).
- SEND_LO / SEND_HI:
  - Wait until TX_BUSY=0, then assert TX_D_VLD with the byte held stable.
  - Drop TX_D_VLD on the first cycle TX_BUSY=1.
  - For 2-byte responses, the LSB goes first. SEND_HI then waits for TX_BUSY=0 again before asserting.
  - After the last byte is accepted -> IDLE.
- TX_D_VLD never asserts while TX_BUSY=1 at assertion time.
- Timeout:
  - The counter runs only in WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B and ALU_FUN.
  - It clears on every accepted byte.
  - Reaching TIMEOUT -> IDLE, no strobes issued.
  - It does not run in RD_WAIT, ALU_WAIT or the SEND states.
- RX bytes arriving during RD_WAIT, ALU_WAIT or the SEND states are dropped. They are not queued.
- RF_WrEn and RF_RdEn are never high together; RF_WrEn is always a single cycle.
- Reset asserted mid-frame or mid-send: immediate return to reset values. TX_D_VLD drops asynchronously.

Test Plan:
- AA,05,3C -> one-cycle RF_WrEn, RF_Address=5, RF_WrData=0x3C; FSM back in IDLE.
- BB,07; RF returns 0x9E after 3 cycles -> RF_RdEn high 3 cycles; TX_D_VLD with TX_P_DATA=0x9E held until TX_BUSY rises.
- CC,12,34,00; ALU_OUT=0x0046 -> RF writes addr0=0x12 and addr1=0x34; ALU_FUN=0 with ALU_EN/CLK_GATE_EN until valid; TX sends 0x46 then 0x00, second only after TX_BUSY falls.
- AA,05 then a byte with RX_ERR=1 -> no RF_WrEn. A following AA,02,11 writes 0x11 to addr 2.
- AA then no byte for TIMEOUT cycles -> return to IDLE. Next bytes 05,3C produce no write (0x05 ignored in IDLE).
- DD,03 with TX_BUSY held high 50 cycles after result -> TX_D_VLD stays 0 until TX_BUSY=0. Reset asserted during SEND_HI clears all outputs and returns to IDLE.
